// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared flag indices and state encoding for the ALU result stage
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational N/Z/C/V derivation from an ALU result word
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] result_i,
    input  logic         carry_i,
    input  logic         overflow_i,
    input  logic         logic_i,
    output logic [3:0]   flags_o
);

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = result_i[W-1];
        flags_o[FLAG_Z] = ~|result_i;
        // Bitwise ops have no meaningful carry/overflow, so they are masked off.
        flags_o[FLAG_C] = carry_i & ~logic_i;
        flags_o[FLAG_V] = overflow_i & ~logic_i;
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result/flags stage with a two-entry skid buffer
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_result,
    input  logic         in_carry,
    input  logic         in_overflow,
    input  logic         in_logic,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic [3:0]   out_flags
);

    stage_state_e state_q, state_d;
    logic [W-1:0] main_result_q, main_result_d;
    logic [3:0]   main_flags_q, main_flags_d;
    logic [W-1:0] skid_result_q, skid_result_d;
    logic [3:0]   skid_flags_q, skid_flags_d;
    logic         in_ready_q, in_ready_d;

    logic [3:0] in_flags;
    logic       in_xfer;
    logic       out_xfer;

    alu_flag_gen #(.W(W)) u_flag_gen (
        .result_i   (in_result),
        .carry_i    (in_carry),
        .overflow_i (in_overflow),
        .logic_i    (in_logic),
        .flags_o    (in_flags)
    );

    assign out_valid  = (state_q == ONE) || (state_q == TWO);
    assign in_ready   = in_ready_q;
    assign out_result = main_result_q;
    assign out_flags  = main_flags_q;
    assign in_xfer    = in_valid && in_ready_q;
    assign out_xfer   = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        main_result_d = main_result_q;
        main_flags_d  = main_flags_q;
        skid_result_d = skid_result_q;
        skid_flags_d  = skid_flags_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d       = ONE;
                    main_result_d = in_result;
                    main_flags_d  = in_flags;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_result_d = in_result;
                    main_flags_d  = in_flags;
                end else if (in_xfer) begin
                    state_d       = TWO;
                    skid_result_d = in_result;
                    skid_flags_d  = in_flags;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d       = ONE;
                    main_result_d = skid_result_q;
                    main_flags_d  = skid_flags_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Registered ready tracks the state we are about to enter.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= EMPTY;
            main_result_q <= '0;
            main_flags_q  <= '0;
            skid_result_q <= '0;
            skid_flags_q  <= '0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            main_result_q <= main_result_d;
            main_flags_q  <= main_flags_d;
            skid_result_q <= skid_result_d;
            skid_flags_q  <= skid_flags_d;
            in_ready_q    <= in_ready_d;
        end
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the ALU bitwise/arithmetic units (NAND, etc.). It accepts one ALU result per cycle under a valid/ready handshake, derives N/Z/C/V status flags, and presents result plus flags to the writeback path. A two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `W`, default 8: datapath width in bits; legal range 1 to 64.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream ALU result is valid.
- `in_ready`  out  1  stage can accept a result this cycle; a registered output.
- `in_result`  in  W  ALU result.
- `in_carry`  in  1  carry-out from the ALU adder path.
- `in_overflow`  in  1  signed overflow from the ALU adder path.
- `in_logic`  in  1  operation was bitwise (NAND/AND/OR/XOR); forces C=V=0.
- `out_valid`  out  1  `out_result` and `out_flags` are valid.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_result`  out  W  registered result.
- `out_flags`  out  4  {N, Z, C, V}: bit 3 = N, bit 0 = V.

## Operation
- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Flags are computed from the input word at capture time:
  - N = `in_result[W-1]`.
  - Z = (`in_result` == 0).
  - C = `in_carry & ~in_logic`.
  - V = `in_overflow & ~in_logic`.
- Storage is a main register (drives the outputs) plus a skid register. Each holds result and flags.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - TWO: main valid, skid valid.
- Transitions ("in" = input transfer, "out" = output transfer):
  - EMPTY: on in, go to ONE.
  - ONE: in without out, go to TWO (word goes to skid). In with out, stay in ONE (main reloads). Out without in, go to EMPTY.
  - TWO: on out, go to ONE and move skid into main. No input transfer is possible in TWO.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is registered, so it reflects the next state.
- Ordering is strict FIFO. No word is dropped or duplicated.
- While `out_valid` && !`out_ready`, `out_result` and `out_flags` hold stable.
- Inputs are ignored when no input transfer occurs. X on data inputs is allowed when `in_valid` = 0.

## Timing
- Latency: 1 cycle. A word accepted at edge k is visible on `out_valid`/`out_result` after edge k.
- Throughput: 1 word/cycle sustained while `out_ready` = 1.
- Reset values: `out_valid` = 0, `out_result` = 0, `out_flags` = 0, `in_ready` = 1, state = EMPTY, skid contents = 0.
- Reset is sampled only at a rising edge. Reset overrides any simultaneous handshake, and in-flight words are discarded.
- The first input transfer is possible on the first edge with `rst_n` = 1.
- Simultaneous in and out in ONE: the old main word leaves and the new word lands in main. No bubble.
- W = 1: N and Z are both derived from bit 0 (N = bit, Z = ~bit).

## Structure
- Shared package/header `alu_pkg` holds:
  - flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - 2-bit state encodings: EMPTY=0, ONE=1, TWO=2. Value 3 is illegal and recovers to EMPTY.
- One sub-module, `alu_flag_gen`: combinational, parameter W. Inputs: result, carry, overflow, logic. Output: 4-bit flags.
- `alu_result_stage` holds the state machine, the main register and the skid register.

## Test plan
All scenarios use W=8.
- Reset check: hold `rst_n`=0 for 3 cycles with `in_valid`=1. Require `out_valid`=0, `in_ready`=1, `out_flags`=0 throughout. After release, the first word is accepted on the first edge.
- Flag generation with `out_ready`=1:
  - 0x00, carry=1, logic=0 → flags 4'b0110.
  - 0x80, overflow=1, logic=0 → 4'b1001.
  - 0xFF, carry=1, logic=1 → 4'b1000.
- Streaming: `out_ready`=1, 16 back-to-back words 0x01..0x10. Require outputs 0x01..0x10 on consecutive cycles, 1-cycle latency, `in_ready` never 0.
- Backpressure/skid: send 0xA1, 0xA2, 0xA3 back-to-back with `out_ready`=0.
  - Require `in_ready`=0 after the second acceptance, so 0xA3 is held upstream.
  - `out_result` holds 0xA1.
  - Raise `out_ready`: require 0xA1, 0xA2, 0xA3 in order with no loss.
- Random valid/ready: 1000 random words with random `in_valid`/`out_ready`, checked against a scoreboard FIFO. Require exact order and flags, and output stable during stalls.
- Mid-operation reset: in state TWO, assert `rst_n`=0 for 1 cycle. Require `out_valid`=0 and `in_ready`=1 next cycle, and no stale word emitted afterward.
